ip4_axi_rd_arb: RTL and testbench

IP4_AXI_RD_ARB -- requirements
Module: ip4_axi_rd_arb

---
 rtl/ip4_axi_rd_arb.sv | 182 ++++++++++++++++++
 tb/tb_ip4_axi_rd_arb.sv | 392 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ip4_axi_rd_arb.sv
// rtl/ip4_axi_rd_arb.sv - round-robin arbiter of internal read requesters onto one AXI3 read port
// Only one burst is in flight at a time, so returning beats are routed by the latched grant.
module ip4_axi_rd_arb #(
    parameter int NUM_REQ      = 4,
    parameter int WID_AXI_ID   = 4,
    parameter int WID_AXI_ADDR = 32,
    parameter int WID_AXI_DATA = 32
) (
    input  logic                            aclk,
    input  logic                            rst,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [NUM_REQ*WID_AXI_ADDR-1:0] req_addr,
    input  logic [NUM_REQ*4-1:0]            req_len,
    output logic [NUM_REQ-1:0]              req_ready,
    output logic [NUM_REQ-1:0]              rsp_valid,
    input  logic [NUM_REQ-1:0]              rsp_ready,
    output logic [WID_AXI_DATA-1:0]         rsp_data,
    output logic [1:0]                      rsp_resp,
    output logic                            rsp_last,
    output logic [WID_AXI_ID-1:0]           arid,
    output logic [WID_AXI_ADDR-1:0]         araddr,
    output logic [3:0]                      arlen,
    output logic [2:0]                      arsize,
    output logic [1:0]                      arburst,
    output logic [1:0]                      arlock,
    output logic [3:0]                      arcache,
    output logic [2:0]                      arprot,
    output logic                            arvalid,
    input  logic                            arready,
    input  logic [WID_AXI_ID-1:0]           rid,
    input  logic [WID_AXI_DATA-1:0]         rdata,
    input  logic [1:0]                      rresp,
    input  logic                            rlast,
    input  logic                            rvalid,
    output logic                            rready,
    output logic                            err,
    output logic                            busy
);

    localparam int GW = $clog2(NUM_REQ);
    localparam logic [2:0] AR_SIZE = 3'($clog2(WID_AXI_DATA / 8));

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA
    } state_t;

    state_t                  state_q, state_d;
    logic [GW-1:0]           ptr_q, ptr_d;
    logic [GW-1:0]           grant_q, grant_d;
    logic [WID_AXI_ADDR-1:0] addr_q, addr_d;
    logic [3:0]              len_q, len_d;
    logic [3:0]              cnt_q, cnt_d;
    logic                    err_q, err_d;

    logic [WID_AXI_ADDR-1:0] addr_arr [NUM_REQ];
    logic [3:0]              len_arr  [NUM_REQ];
    logic                    found;
    logic [GW-1:0]           sel;
    logic [GW:0]             idx_w;
    logic [GW-1:0]           idx;
    logic                    data_fire;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            addr_arr[i] = req_addr[i*WID_AXI_ADDR +: WID_AXI_ADDR];
            len_arr[i]  = req_len[i*4 +: 4];
        end
    end

    // Rotating priority: first requester at or after ptr_q, wrapping past NUM_REQ-1.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        idx_w = '0;
        idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx_w = {1'b0, ptr_q} + (GW+1)'(k);
            if (idx_w >= (GW+1)'(NUM_REQ)) begin
                idx_w = idx_w - (GW+1)'(NUM_REQ);
            end
            idx = idx_w[GW-1:0];
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                sel   = idx;
            end
        end
    end

    assign data_fire = rvalid && rsp_ready[grant_q];

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        grant_d   = grant_q;
        addr_d    = addr_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        req_ready = '0;
        rsp_valid = '0;
        rready    = 1'b0;
        arvalid   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (rvalid) begin
                    err_d = 1'b1;
                end
                if (found) begin
                    req_ready[sel] = 1'b1;
                    grant_d        = sel;
                    addr_d         = addr_arr[sel];
                    len_d          = len_arr[sel];
                    state_d        = ST_ADDR;
                end
            end
            ST_ADDR: begin
                arvalid = 1'b1;
                if (rvalid) begin
                    err_d = 1'b1;
                end
                if (arready) begin
                    cnt_d   = len_q;
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                rready             = rsp_ready[grant_q];
                rsp_valid[grant_q] = rvalid;
                if (data_fire) begin
                    if (rid != WID_AXI_ID'(grant_q) || (rlast != (cnt_q == 4'd0))) begin
                        err_d = 1'b1;
                    end
                    // The beat count, not rlast, decides where the burst ends.
                    if (cnt_q == 4'd0) begin
                        state_d = ST_IDLE;
                        ptr_d   = (grant_q == GW'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            grant_q <= '0;
            addr_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign arid     = WID_AXI_ID'(grant_q);
    assign araddr   = addr_q;
    assign arlen    = len_q;
    assign arsize   = AR_SIZE;
    assign arburst  = 2'b01;
    assign arlock   = 2'b00;
    assign arcache  = 4'b0000;
    assign arprot   = 3'b000;
    assign rsp_data = rdata;
    assign rsp_resp = rresp;
    assign rsp_last = rlast;
    assign err      = err_q;
    assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ip4_axi_rd_arb.sv
// tb/tb_ip4_axi_rd_arb.sv - scoreboard bench for ip4_axi_rd_arb with a randomized AXI read slave
module tb_ip4_axi_rd_arb;
    localparam int N  = 4;
    localparam int IW = 4;
    localparam int AW = 32;
    localparam int DW = 32;

    logic            aclk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N*AW-1:0] req_addr;
    logic [N*4-1:0]  req_len;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    rsp_valid;
    logic [N-1:0]    rsp_ready;
    logic [DW-1:0]   rsp_data;
    logic [1:0]      rsp_resp;
    logic            rsp_last;
    logic [IW-1:0]   arid;
    logic [AW-1:0]   araddr;
    logic [3:0]      arlen;
    logic [2:0]      arsize;
    logic [1:0]      arburst;
    logic [1:0]      arlock;
    logic [3:0]      arcache;
    logic [2:0]      arprot;
    logic            arvalid;
    logic            arready;
    logic [IW-1:0]   rid;
    logic [DW-1:0]   rdata;
    logic [1:0]      rresp;
    logic            rlast;
    logic            rvalid;
    logic            rready;
    logic            err;
    logic            busy;

    always #5 aclk = ~aclk;

    ip4_axi_rd_arb #(.NUM_REQ(N), .WID_AXI_ID(IW), .WID_AXI_ADDR(AW), .WID_AXI_DATA(DW)) dut (
        .aclk(aclk), .rst(rst),
        .req_valid(req_valid), .req_addr(req_addr), .req_len(req_len), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_resp(rsp_resp), .rsp_last(rsp_last),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .err(err), .busy(busy)
    );

    typedef struct { int g; logic [31:0] addr; logic [3:0] len; } ar_t;
    typedef struct { logic [31:0] data; logic [1:0] resp; logic last; } beat_t;

    ar_t   exp_ar_q[$];
    beat_t exp_beat_q[$];
    int    checks = 0;
    int    errors = 0;

    // Reference model: pending requests and the rotating pointer.
    int          m_ptr;
    logic [N-1:0] pending;
    logic [31:0] m_addr [N];
    logic [3:0]  m_len  [N];

    // Slave knobs and state.
    bit          ar_fast = 0;
    int          ar_hold_lo = 0;
    bit          inj_rid = 0;
    int          inj_last = -1;
    bit          sl_active = 0;
    logic [31:0] sl_addr;
    int          sl_len, sl_beat;
    logic [3:0]  sl_id;
    bit          ar_fire_p = 0, r_fire_p = 0;
    logic [31:0] cap_addr;
    int          cap_len;
    logic [3:0]  cap_id;
    int          beats_seen = 0;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
        end
    endtask

    function automatic logic [31:0] beat_data(logic [31:0] a, int b);
        return a ^ (32'h01010101 * 32'(b)) ^ 32'h5A5A0000;
    endfunction

    function automatic logic [1:0] beat_resp(logic [31:0] a, int b);
        return 2'(b) ^ a[5:4];
    endfunction

    // AXI read slave: random arready/rvalid, data derived from the captured address.
    initial begin
        arready = 0; rvalid = 0; rid = '0; rdata = '0; rresp = '0; rlast = 0; rsp_ready = '0;
        forever begin
            bit keep;
            @(negedge aclk);
            keep = rvalid && !r_fire_p;
            if (rst) begin
                sl_active = 0;
                keep = 0;
            end else begin
                if (r_fire_p) begin
                    sl_beat++;
                    if (sl_beat > sl_len) sl_active = 0;
                end
                if (ar_fire_p) begin
                    sl_active = 1; sl_addr = cap_addr; sl_len = cap_len; sl_beat = 0; sl_id = cap_id;
                end
            end
            if (ar_hold_lo > 0) begin
                arready = 0;
                ar_hold_lo--;
            end else begin
                arready = ar_fast ? 1'b1 : ($urandom_range(0, 2) != 0);
            end
            if (!sl_active) rvalid = 0;
            else if (!keep) rvalid = ($urandom_range(0, 3) != 0);
            if (sl_active) begin
                rdata = beat_data(sl_addr, sl_beat);
                rresp = beat_resp(sl_addr, sl_beat);
                rid   = inj_rid ? (sl_id ^ 4'd1) : sl_id;
                rlast = (inj_last >= 0) ? (sl_beat == inj_last) : (sl_beat == sl_len);
            end
            rsp_ready = 4'($urandom);
            #2;
            ar_fire_p = arvalid && arready && !rst;
            if (ar_fire_p) begin
                cap_addr = araddr; cap_len = int'(arlen); cap_id = arid;
            end
            r_fire_p = rvalid && rready && !rst;
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents an AR or a beat handshake.
    initial begin
        bit          in_data = 0;
        int          cur_g = 0;
        int          beats_left = 0;
        bit          prev_stall = 0;
        logic [31:0] prev_addr;
        logic [3:0]  prev_len;
        logic [3:0]  prev_id;
        forever begin
            bit   ar_fire;
            ar_t  ea;
            beat_t eb;
            @(negedge aclk);
            #3;
            if (rst) begin
                in_data = 0;
                prev_stall = 0;
            end else begin
                if (prev_stall) begin
                    chk("ar_hold_valid", 64'(arvalid), 64'd1);
                    chk("ar_stable_addr", 64'(araddr), 64'(prev_addr));
                    chk("ar_stable_len", 64'(arlen), 64'(prev_len));
                    chk("ar_stable_id", 64'(arid), 64'(prev_id));
                end
                prev_stall = arvalid && !arready;
                prev_addr = araddr; prev_len = arlen; prev_id = arid;
                ar_fire = arvalid && arready;
                if (ar_fire) begin
                    if (exp_ar_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL ar_unexpected: got arid %0h expected no request", arid);
                        ea.g = int'(arid); ea.addr = araddr; ea.len = arlen;
                    end else begin
                        ea = exp_ar_q.pop_front();
                        chk("arid", 64'(arid), 64'(ea.g));
                        chk("araddr", 64'(araddr), 64'(ea.addr));
                        chk("arlen", 64'(arlen), 64'(ea.len));
                        chk("arsize", 64'(arsize), 64'd2);
                        chk("arburst", 64'(arburst), 64'd1);
                        chk("ar_lock_cache_prot", 64'({arlock, arcache, arprot}), 64'd0);
                    end
                end
                chk("rready", 64'(rready), in_data ? 64'(rsp_ready[cur_g]) : 64'd0);
                chk("rsp_valid", 64'(rsp_valid), (in_data && rvalid) ? (64'd1 << cur_g) : 64'd0);
                if (in_data && rvalid && rready) begin
                    beats_seen++;
                    if (exp_beat_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL beat_unexpected: got data %0h expected none", rsp_data);
                    end else begin
                        eb = exp_beat_q.pop_front();
                        chk("rsp_data", 64'(rsp_data), 64'(eb.data));
                        chk("rsp_resp", 64'(rsp_resp), 64'(eb.resp));
                        chk("rsp_last", 64'(rsp_last), 64'(eb.last));
                    end
                    beats_left--;
                    if (beats_left == 0) in_data = 0;
                end
                if (ar_fire) begin
                    in_data = 1;
                    cur_g = ea.g;
                    beats_left = int'(ea.len) + 1;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wait_idle();
        int n = 0;
        @(negedge aclk);
        while (busy !== 1'b0 && n < 400) begin
            @(negedge aclk);
            n++;
        end
        if (n >= 400) begin
            checks++; errors++;
            $display("FAIL idle_timeout: busy stuck at %0b expected 0", busy);
        end
    endtask

    task automatic do_reset(int cycles);
        rst = 1;
        exp_ar_q.delete();
        exp_beat_q.delete();
        pending = '0;
        req_valid = '0;
        repeat (cycles) @(negedge aclk);
        rst = 0;
        m_ptr = 0;
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_arvalid", 64'(arvalid), 64'd0);
        chk("rst_rready", 64'(rready), 64'd0);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
    endtask

    // Called on the idle negedge: presents pending requests, predicts the grant, queues expectations.
    task automatic start_round();
        int    g = -1;
        ar_t   a;
        beat_t b;
        for (int i = 0; i < N; i++) begin
            req_addr[i*AW +: AW] = m_addr[i];
            req_len[i*4 +: 4]    = m_len[i];
        end
        req_valid = pending;
        for (int k = 0; k < N; k++) begin
            int i = (m_ptr + k) % N;
            if (g < 0 && pending[i]) g = i;
        end
        a.g = g; a.addr = m_addr[g]; a.len = m_len[g];
        exp_ar_q.push_back(a);
        for (int bi = 0; bi <= int'(m_len[g]); bi++) begin
            b.data = beat_data(m_addr[g], bi);
            b.resp = beat_resp(m_addr[g], bi);
            b.last = (inj_last >= 0) ? (bi == inj_last) : (bi == int'(m_len[g]));
            exp_beat_q.push_back(b);
        end
        m_ptr = (g + 1) % N;
        #1;
        chk("req_ready", 64'(req_ready), 64'd1 << g);
        @(posedge aclk);
        #1;
        pending[g] = 1'b0;
        req_valid[g] = 1'b0;
        @(negedge aclk);
        chk("ar_latency", 64'(arvalid), 64'd1);
    endtask

    initial begin
        rst = 1;
        req_valid = '0;
        req_addr = '0;
        req_len = '0;
        pending = '0;
        m_ptr = 0;
        for (int i = 0; i < N; i++) begin
            m_addr[i] = 32'h1000 * 32'(i + 1);
            m_len[i] = 4'd1;
        end
        do_reset(3);

        // Single request with immediate arready.
        ar_fast = 1;
        wait_idle();
        pending = 4'b0100; m_addr[2] = 32'h100; m_len[2] = 4'd3;
        start_round();
        wait_idle();
        chk("single_err", 64'(err), 64'd0);
        ar_fast = 0;

        // Fairness: all requesters held, len 0.
        do_reset(2);
        for (int r = 0; r < 5; r++) begin
            wait_idle();
            pending = 4'hF;
            for (int i = 0; i < N; i++) begin
                m_len[i] = 4'd0;
                m_addr[i] = $urandom & 32'hFFFF_FFFC;
            end
            start_round();
        end

        // Address-channel backpressure with toggling rsp_ready.
        wait_idle();
        pending = 4'b1000; m_addr[3] = 32'h0000_8000; m_len[3] = 4'd7;
        ar_hold_lo = 6;
        start_round();

        // Randomized traffic.
        for (int r = 0; r < 40; r++) begin
            wait_idle();
            for (int i = 0; i < N; i++) begin
                if (!pending[i] && $urandom_range(0, 1) == 1) begin
                    pending[i] = 1'b1;
                    m_addr[i] = $urandom & 32'hFFFF_FFFC;
                    m_len[i] = 4'($urandom_range(0, 7));
                end
            end
            if (pending == '0) pending[$urandom_range(0, N-1)] = 1'b1;
            start_round();
        end
        wait_idle();
        chk("random_err_clean", 64'(err), 64'd0);

        // Wrong rid on grant 0, then sticky across a clean burst.
        do_reset(2);
        wait_idle();
        pending = 4'b0001; m_len[0] = 4'd3; inj_rid = 1;
        start_round();
        wait_idle();
        inj_rid = 0;
        chk("err_rid", 64'(err), 64'd1);
        pending = 4'b0010; m_len[1] = 4'd1;
        start_round();
        wait_idle();
        chk("err_sticky", 64'(err), 64'd1);

        // Early rlast on beat 2 of a 4-beat burst.
        do_reset(2);
        wait_idle();
        pending = 4'b0001; m_len[0] = 4'd3; inj_last = 1;
        start_round();
        wait_idle();
        inj_last = -1;
        chk("err_early_last", 64'(err), 64'd1);

        // Reset in the middle of a burst; pointer must return to 0.
        do_reset(2);
        wait_idle();
        pending = 4'b0100; m_len[2] = 4'd0;
        start_round();
        wait_idle();
        pending = 4'b0010; m_len[1] = 4'd3;
        begin
            int base = beats_seen;
            int n = 0;
            start_round();
            while (beats_seen < base + 2 && n < 300) begin
                @(negedge aclk);
                n++;
            end
            if (n >= 300) begin
                checks++; errors++;
                $display("FAIL midburst_timeout: beats %0d expected %0d", beats_seen - base, 2);
            end
        end
        do_reset(2);
        wait_idle();
        pending = 4'b1010; m_len[1] = 4'd1; m_len[3] = 4'd2;
        start_round();
        wait_idle();
        start_round();
        wait_idle();
        chk("post_reset_err", 64'(err), 64'd0);

        repeat (3) @(negedge aclk);
        chk("exp_ar_drained", 64'(exp_ar_q.size()), 64'd0);
        chk("exp_beat_drained", 64'(exp_beat_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
